// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: one round key per clock into an 11-entry register file,
// then served combinationally by index in forward or reverse (decrypt) order.
module aes_key_schedule #(
  parameter int unsigned NR         = 10,
  parameter bit          REVERSE_RD = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         key_ready_o,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] round_key_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EXPAND = 2'b01,
    READY  = 2'b10
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_e       state_q, state_d;
  logic [127:0] rk_q [NR+1];
  logic [7:0]   rcon_q;
  logic [3:0]   rnd_q;
  logic         accept;
  logic [127:0] prev_key;
  logic [31:0]  t_word, n0, n1, n2, n3;
  logic [3:0]   rd_sel;

  assign accept = start_i && ((state_q == IDLE) || (state_q == READY));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, READY: if (start_i) state_d = EXPAND;
      EXPAND:      if (rnd_q == 4'(NR)) state_d = READY;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q == EXPAND);
    key_ready_o = (state_q == READY);
  end

  // Previous round key is rk[rnd-1]; rnd is always 1..NR while expanding.
  always_comb begin
    prev_key = rk_q[0];
    for (int unsigned i = 1; i < NR; i++)
      if (rnd_q == 4'(i + 1)) prev_key = rk_q[i];
  end

  assign t_word = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon_q, 24'h0};
  assign n0     = prev_key[127:96] ^ t_word;
  assign n1     = prev_key[95:64]  ^ n0;
  assign n2     = prev_key[63:32]  ^ n1;
  assign n3     = prev_key[31:0]   ^ n2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
      rcon_q <= 8'h01;
      rnd_q  <= '0;
    end else if (accept) begin
      rk_q[0] <= key_i;
      rnd_q   <= 4'd1;
      rcon_q  <= 8'h01;
    end else if (state_q == EXPAND) begin
      for (int unsigned i = 1; i <= NR; i++)
        if (rnd_q == 4'(i)) rk_q[i] <= {n0, n1, n2, n3};
      rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      rnd_q  <= rnd_q + 4'd1;
    end
  end

  always_comb begin
    rd_sel      = REVERSE_RD ? (4'(NR) - rd_idx_i) : rd_idx_i;
    round_key_o = '0;
    if (rd_idx_i <= 4'(NR))
      for (int unsigned i = 0; i <= NR; i++)
        if (rd_sel == 4'(i)) round_key_o = rk_q[i];
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: a GF(2^8)-derived reference key expansion
// predicts every round key; a monitor sweeps the read port whenever key_ready_o rises.
`timescale 1ns/1ps
module tb_aes_key_schedule;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         busy_o, key_ready_o;
  logic [3:0]   rd_idx_i = '0;
  logic [127:0] round_key_o;

  always #5 clk_i = ~clk_i;

  aes_key_schedule #(.NR(10), .REVERSE_RD(1'b1)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .key_i       (key_i),
    .busy_o      (busy_o),
    .key_ready_o (key_ready_o),
    .rd_idx_i    (rd_idx_i),
    .round_key_o (round_key_o)
  );

  typedef struct packed {
    logic [10:0][127:0] rk;
    logic [31:0]        start_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0, n_err = 0, done_cnt = 0;
  logic [31:0] cyc = 0;
  logic [7:0]  sbox_m [256];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic exp_t model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    exp_t        e;
    e  = '0;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) e.rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return e;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issue(input logic [127:0] key, input exp_t e_in);
    exp_t e;
    e = e_in;
    @(negedge clk_i);
    key_i   = key;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    key_i   = rand128();
    e.start_cyc = cyc;
    sb.push_back(e);
    @(negedge clk_i);
    chk("busy_after_start", 128'(busy_o), 128'd1);
    chk("ready_after_start", 128'(key_ready_o), 128'd0);
  endtask

  task automatic wait_done(input int unsigned n);
    int unsigned k;
    k = 0;
    while (done_cnt < n && k < 60) begin
      @(negedge clk_i);
      k++;
    end
    chk("expansion_completed", 128'(done_cnt >= n), 128'd1);
  endtask

  // Monitor: on each rising key_ready_o, check latency and sweep all 16 read indices.
  initial begin : monitor
    bit   ready_seen;
    exp_t e;
    logic [127:0] exp_v;
    ready_seen = 1'b0;
    forever begin
      @(negedge clk_i);
      if (key_ready_o && !ready_seen) begin
        ready_seen = 1'b1;
        if (sb.size() == 0) begin
          chk("unexpected_ready", 128'(key_ready_o), 128'd0);
        end else begin
          e = sb.pop_front();
          chk("ready_latency", 128'(cyc - e.start_cyc), 128'd10);
          chk("busy_at_ready", 128'(busy_o), 128'd0);
          for (int unsigned idx = 0; idx < 16; idx++) begin
            rd_idx_i = 4'(idx);
            #1;
            exp_v = (idx <= 10) ? e.rk[10 - idx] : '0;
            chk($sformatf("round_key_idx%0d", idx), round_key_o, exp_v);
          end
          rd_idx_i = '0;
          done_cnt++;
        end
      end
      if (!key_ready_o) ready_seen = 1'b0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    exp_t         e;
    logic [127:0] k1, k4, kr;
    k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k4 = 128'h000102030405060708090a0b0c0d0e0f;
    build_sbox();

    #1;
    chk("reset_busy", 128'(busy_o), 128'd0);
    chk("reset_ready", 128'(key_ready_o), 128'd0);
    chk("reset_round_key", round_key_o, 128'h0);
    #20;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // FIPS-197 A.1 with known-answer round keys.
    e = model(k1);
    e.rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    e.rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    issue(k1, e);
    wait_done(1);

    // start_i pulses during EXPAND must be ignored.
    issue(k1, e);
    repeat (2) @(negedge clk_i);
    start_i = 1'b1; key_i = k4;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    start_i = 1'b1; key_i = rand128();
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(2);

    // Restart from READY (FIPS-197 C.1 key).
    e = model(k4);
    e.rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    issue(k4, e);
    wait_done(3);

    // Asynchronous reset in the middle of expansion.
    kr = rand128();
    issue(kr, model(kr));
    repeat (4) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midreset_busy", 128'(busy_o), 128'd0);
    chk("midreset_ready", 128'(key_ready_o), 128'd0);
    chk("midreset_round_key", round_key_o, 128'h0);
    sb.delete(sb.size() - 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("post_reset_idle_busy", 128'(busy_o), 128'd0);
    chk("post_reset_idle_ready", 128'(key_ready_o), 128'd0);
    kr = rand128();
    issue(kr, model(kr));
    wait_done(4);

    for (int unsigned i = 0; i < 5; i++) begin
      kr = rand128();
      issue(kr, model(kr));
      wait_done(5 + i);
    end

    repeat (2) @(negedge clk_i);
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
